instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  PC register and IF stage of the RISC-V datapath. Drives the byte address of the asynchronous
//  instruction memory and samples its 32-bit little-endian word into an IF/ID register.
//  Delivers the word to decode over a valid/ready handshake, accepts PC redirects from EX,
//  and halts on SYSTEM/zero words, misaligned redirects or out-of-range fetches.
// PARAMETERS
//  RESET_PC   64'h0  PC loaded on reset
//  MEM_BYTES  256    instruction memory size in bytes; highest legal fetch PC is MEM_BYTES-4
// PORTS
//  clk             in   1   rising-edge clock
//  reset_n         in   1   synchronous active-low reset
//  imem_addr       out  64  fetch byte address (= pc); combinational from pc
//  imem_rdata      in   32  instruction word, combinationally valid in the same cycle
//  id_ready        in   1   decode accepts if_id_* this cycle
//  if_id_valid     out  1   if_id_instr/if_id_pc hold an undelivered instruction
//  if_id_instr     out  32  fetched instruction
//  if_id_pc        out  64  address of if_id_instr
//  redirect_valid  in   1   EX branch/jump taken; flush and refetch
//  redirect_pc     in   64  redirect target
//  halted          out  1   fetch stopped (sticky until reset)
//  fault           out  1   halt caused by misaligned redirect or out-of-range PC
//  fetch_count     out  32  number of instructions loaded into IF/ID (wraps at 2^32)
// BEHAVIOUR
//  - Reset (reset_n=0 at edge, overrides everything, including mid-operation): pc=RESET_PC,
//    state=BOOT, if_id_valid=0, if_id_instr=0, if_id_pc=0, halted=0, fault=0, fetch_count=0.
//  - FSM: BOOT -> RUN unconditionally after 1 cycle; RUN -> HALT on a halt condition;
//    HALT is terminal until reset. halted = (state==HALT).
//  - load = (state==RUN) && (!if_id_valid || id_ready) && !redirect_valid.
//  - Handshake: an instruction transfers when if_id_valid && id_ready. If it transfers with
//    no new load, if_id_valid drops to 0. While if_id_valid && !id_ready, if_id_*, pc and
//    fetch_count hold.
//  - On load with a legal word: if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1,
//    pc<=pc+4 (64-bit modulo), fetch_count+=1. Throughput is 1 instruction/cycle.
//  - Redirect (RUN only, priority over load and stall): if_id_valid<=0 (in-flight word is
//    discarded even if id_ready=1); pc<=redirect_pc. If redirect_pc[1:0]!=0, go to HALT
//    with fault=1 and pc unchanged.
//  - Range check at load: if pc > MEM_BYTES-4, there is no load. The FSM goes to HALT with
//    fault=1 and pc unchanged.
//  - SYSTEM/zero check at load: if imem_rdata[6:0]==7'b1110011 or imem_rdata==0, the word is
//    not loaded. The FSM goes to HALT with fault=0, pc holds the word's address, and
//    fetch_count is unchanged. A valid IF/ID word already held still drains via the handshake.
//  - In HALT and BOOT: pc holds, no loads, and redirect_valid is ignored.
//  - Latency: word at pc is visible on if_id_* 1 cycle after imem_addr=pc.
// TESTING
//  1 Reset 2 cycles, release, id_ready=1 with the standard program image -> BOOT 1 cycle, then
//    if_id = (0x00002083,pc 0), (0x00802103,4), (0x002081B3,8) on consecutive cycles,
//    and fetch_count = 1,2,3.
//  2 id_ready=0 for 3 cycles while holding (0x00802103,4) -> if_id_*, imem_addr=8 and
//    fetch_count=2 stable; releasing gives (0x002081B3,8) next cycle.
//  3 redirect_valid=1, redirect_pc=0x10, id_ready=0 -> next cycle if_id_valid=0 and
//    imem_addr=0x10; following cycle if_id=(0x00302C23,0x10).
//  4 redirect_pc=0x6 -> halted=1, fault=1, if_id_valid=0, pc stays 0x6, and later
//    redirect_valid is ignored.
//  5 Bench memory returns 0x00000073 at pc 0x24 -> halted=1, fault=0, pc=0x24, word not
//    delivered, fetch_count=9. With MEM_BYTES=36, reaching pc 0x24 -> halted=1, fault=1.
//  6 reset_n=0 for 1 cycle mid-run with if_id_valid=1 -> next edge all outputs at reset
//    values; the fetch sequence restarts from pc 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC register and IF stage with IF/ID valid/ready handoff
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   imem_addr      fetch byte address, equal to the current pc
//   imem_rdata     instruction word read combinationally at imem_addr
//   id_ready       decode accepts the IF/ID register this cycle
//   if_id_valid    IF/ID register holds an undelivered instruction
//   if_id_instr    fetched instruction word
//   if_id_pc       address of if_id_instr
//   redirect_valid taken branch/jump from EX: flush and refetch
//   redirect_pc    redirect target
//   halted         fetch stopped, sticky until reset
//   fault          halt caused by a misaligned redirect or an out-of-range pc
//   fetch_count    instructions loaded into IF/ID, wraps at 2^32
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [63:0] if_id_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] ipc_q, ipc_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic        can_load;
    logic        out_of_range;
    logic        stop_word;

    // The IF/ID slot is free when empty or being drained this cycle.
    assign can_load     = !valid_q || id_ready;
    assign out_of_range = pc_q > LAST_PC;
    assign stop_word    = (imem_rdata[6:0] == 7'b1110011) || (imem_rdata == 32'h0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        // Default handshake: a delivered word leaves the slot, otherwise it holds.
        valid_d = valid_q && !id_ready;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        fault_d = fault_q;
        count_d = count_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    // The in-flight word is on the wrong path, even if decode takes it now.
                    valid_d = 1'b0;
                    pc_d    = redirect_pc;
                    if (redirect_pc[1:0] != 2'b00) begin
                        // pc keeps the faulting target so it can be inspected after the halt.
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end
                end else if (can_load) begin
                    if (out_of_range) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end else if (stop_word) begin
                        // pc stays on the stopping word; anything already in IF/ID still drains.
                        state_d = ST_HALT;
                    end else begin
                        valid_d = 1'b1;
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        pc_d    = pc_q + 64'd4;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            ipc_q   <= 64'h0;
            fault_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ipc_q;
    assign halted      = (state_q == ST_HALT);
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule
